data_mem_responder: RTL and testbench

- Word-addressed data memory acting as the responder for the load/store word datapath. The datapath is the initiator.
- It accepts one LW/SW request at a time over a valid/ready handshake, inserts a configurable number of wait states, then returns a response.
- The response carries read data or a write acknowledge, plus an error flag for misaligned or out-of-range addresses.
- It sits between the ALU address output / RF read port 2 and the write-back mux.

---
 rtl/dm_pkg.sv | 21 ++
 rtl/dm_word_array.sv | 40 ++++
 rtl/data_mem_responder.sv | 154 +++++++++++++++
 tb/tb_data_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the load/store data memory responder.
// State encodings, word geometry and the alignment pattern used by the address check.
package dm_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      RESP = ST_RESP
   } dm_state_e;

   localparam int WORD_BYTES = 4;
   localparam logic [1:0] ALIGN_MASK = 2'b00;

   // Max wait-state count representable by the wait counter.
   localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/dm_word_array.sv
// DEPTH_WORDS x 32 storage with an asynchronous active-low clear,
// one write port and one registered read port.
module dm_word_array
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_index,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Reset wipes every word, so a store caught mid-flight can never survive it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_index] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_index];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one LW/SW at a time over valid/ready,
// a fixed number of wait states, then a held response with an error flag.
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Req_Valid,
   input  logic        Req_Write,
   input  logic [31:0] Req_Addr,
   input  logic [31:0] Req_WData,
   output logic        Req_Ready,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [31:0] Rsp_RData,
   output logic        Rsp_Error,
   output logic        Busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   dm_state_e state;
   dm_state_e next_state;

   logic [3:0]  wait_count;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        accept;
   logic        complete;
   logic        cur_write;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic        addr_error;
   logic [IDX_W-1:0] word_index;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;

   logic        rsp_error;
   logic        rsp_load_ok;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // With zero wait states the request completes on its own acceptance edge.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (Req_Valid) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  complete   = 1'b1;
                  next_state = RESP;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_count == 4'd0) begin
               complete   = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            if (Rsp_Ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // In IDLE the live request is used directly so the zero-wait build needs no latch cycle.
   always_comb begin
      cur_write  = lat_write;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      if (state == IDLE) begin
         cur_write = Req_Write;
         cur_addr  = Req_Addr;
         cur_wdata = Req_WData;
      end
      addr_error = (cur_addr[1:0] != ALIGN_MASK) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
      word_index = cur_addr[IDX_W+1:2];
      mem_we     = complete && cur_write && !addr_error;
      mem_re     = complete && !cur_write && !addr_error;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         wait_count <= '0;
      end else if (accept) begin
         lat_write  <= Req_Write;
         lat_addr   <= Req_Addr;
         lat_wdata  <= Req_WData;
         wait_count <= WAIT_INIT;
      end else if ((state == WAIT) && (wait_count != 4'd0)) begin
         wait_count <= wait_count - 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rsp_error   <= 1'b0;
         rsp_load_ok <= 1'b0;
      end else if (complete) begin
         rsp_error   <= addr_error;
         rsp_load_ok <= mem_re;
      end else if ((state == RESP) && Rsp_Ready) begin
         rsp_error   <= 1'b0;
         rsp_load_ok <= 1'b0;
      end
   end

   dm_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_word_array (
      .clk      (CLK),
      .rst_n    (RST),
      .wr_en    (mem_we),
      .wr_index (word_index),
      .wr_data  (cur_wdata),
      .rd_en    (mem_re),
      .rd_index (word_index),
      .rd_data  (mem_rdata)
   );

   // The array read register only moves on a good load, so gating it holds data stable in RESP.
   assign Rsp_RData = rsp_load_ok ? mem_rdata : 32'd0;
   assign Rsp_Error = rsp_error;
   assign Req_Ready = (state == IDLE);
   assign Rsp_Valid = (state == RESP);
   assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a WAIT_STATES=2 instance driven by directed and
// random requests against an array model, plus a WAIT_STATES=0 instance for throughput.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WS    = 2;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST;

   logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_error, a_busy;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_error, b_busy;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] ref_mem [DEPTH];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut_a (
      .CLK(CLK), .RST(RST),
      .Req_Valid(a_req_valid), .Req_Write(a_req_write), .Req_Addr(a_req_addr), .Req_WData(a_req_wdata),
      .Req_Ready(a_req_ready), .Rsp_Valid(a_rsp_valid), .Rsp_Ready(a_rsp_ready),
      .Rsp_RData(a_rsp_rdata), .Rsp_Error(a_rsp_error), .Busy(a_busy)
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
      .CLK(CLK), .RST(RST),
      .Req_Valid(b_req_valid), .Req_Write(b_req_write), .Req_Addr(b_req_addr), .Req_WData(b_req_wdata),
      .Req_Ready(b_req_ready), .Rsp_Valid(b_rsp_valid), .Rsp_Ready(b_rsp_ready),
      .Rsp_RData(b_rsp_rdata), .Rsp_Error(b_rsp_error), .Busy(b_busy)
   );

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One request on instance A; the expected response is derived from the byte-address rules.
   task automatic apply_request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int stall, input logic hold_valid, input string tag);
      int edges;
      logic err;
      logic [31:0] exp_rdata;
      err = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
      exp_rdata = 32'd0;
      if (!err) begin
         if (wr) ref_mem[addr / 4] = wdata;
         else    exp_rdata = ref_mem[addr / 4];
      end
      a_rsp_ready = (stall == 0);
      check_output({tag, "/req_ready_idle"}, {31'd0, a_req_ready}, 32'd1);
      a_req_valid = 1'b1;
      a_req_write = wr;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      edges = 0;
      do begin
         step();
         edges++;
         if (!hold_valid) begin
            a_req_valid = 1'b0;
            a_req_write = 1'($urandom);
            a_req_addr  = $urandom;
            a_req_wdata = $urandom;
         end
      end while (!a_rsp_valid && edges < 50);
      check_output({tag, "/latency"}, 32'(edges), 32'(WS + 1));
      check_output({tag, "/rdata"}, a_rsp_rdata, exp_rdata);
      check_output({tag, "/error"}, {31'd0, a_rsp_error}, {31'd0, err});
      check_output({tag, "/busy"}, {31'd0, a_busy}, 32'd1);
      for (int s = 0; s < stall; s++) begin
         step();
         check_output({tag, "/stall_valid"}, {31'd0, a_rsp_valid}, 32'd1);
         check_output({tag, "/stall_rdata"}, a_rsp_rdata, exp_rdata);
         check_output({tag, "/stall_error"}, {31'd0, a_rsp_error}, {31'd0, err});
         check_output({tag, "/stall_req_ready"}, {31'd0, a_req_ready}, 32'd0);
      end
      a_rsp_ready = 1'b1;
      a_req_valid = 1'b0;
      step();
      check_output({tag, "/idle_rsp_valid"}, {31'd0, a_rsp_valid}, 32'd0);
      check_output({tag, "/idle_req_ready"}, {31'd0, a_req_ready}, 32'd1);
      check_output({tag, "/idle_busy"}, {31'd0, a_busy}, 32'd0);
      check_output({tag, "/idle_rdata"}, a_rsp_rdata, 32'd0);
      check_output({tag, "/idle_error"}, {31'd0, a_rsp_error}, 32'd0);
   endtask

   initial begin
      int b_done;
      logic [31:0] raddr;
      int r;

      RST = 1'b0;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

      step();
      step();
      #2 RST = 1'b1;
      step();
      check_output("reset/req_ready", {31'd0, a_req_ready}, 32'd1);
      check_output("reset/rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check_output("reset/busy", {31'd0, a_busy}, 32'd0);
      check_output("reset/rdata", a_rsp_rdata, 32'd0);
      apply_request(1'b0, 32'h0, 32'h0, 0, 1'b0, "lw_0_after_reset");

      apply_request(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, "sw_10");
      apply_request(1'b0, 32'h10, 32'h0, 0, 1'b0, "lw_10");
      apply_request(1'b0, 32'h12, 32'h0, 0, 1'b0, "lw_misaligned");
      apply_request(1'b1, 32'h100, 32'h12345678, 0, 1'b0, "sw_out_of_range");
      apply_request(1'b0, 32'h0FC, 32'h0, 0, 1'b0, "lw_fc_unchanged");
      apply_request(1'b1, 32'h0FC, 32'h0BADF00D, 0, 1'b0, "sw_last_word");
      apply_request(1'b0, 32'h0FC, 32'h0, 0, 1'b0, "lw_last_word");
      apply_request(1'b0, 32'h10, 32'h0, 5, 1'b1, "backpressure");
      step();
      check_output("no_double_accept/busy", {31'd0, a_busy}, 32'd0);

      // Reset while a store sits in WAIT.
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D;
      step();
      a_req_valid = 1'b0;
      check_output("midreset/busy_before", {31'd0, a_busy}, 32'd1);
      #2 RST = 1'b0;
      #1;
      check_output("midreset/rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      check_output("midreset/req_ready", {31'd0, a_req_ready}, 32'd1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      step();
      step();
      #2 RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_output("midreset/no_response", {31'd0, a_rsp_valid}, 32'd0);
      end
      apply_request(1'b0, 32'h20, 32'h0, 0, 1'b0, "lw_20_after_reset");
      apply_request(1'b0, 32'h10, 32'h0, 0, 1'b0, "lw_10_after_reset");

      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      raddr = 32'($urandom_range(0, 7)) * 4;
         else if (r < 7) raddr = 32'($urandom_range(0, DEPTH - 1)) * 4;
         else if (r == 7) raddr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         else if (r == 8) raddr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
         else             raddr = {$urandom_range(1, 255), 24'h0};
         apply_request(1'($urandom_range(0, 1)), raddr, $urandom, $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      end

      // Zero-wait-state instance: completion on the acceptance edge, one request per 2 cycles.
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hA5A50001;
      step();
      b_req_valid = 1'b0;
      check_output("ws0_sw/rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
      check_output("ws0_sw/error", {31'd0, b_rsp_error}, 32'd0);
      check_output("ws0_sw/rdata", b_rsp_rdata, 32'd0);
      step();
      check_output("ws0_sw/req_ready", {31'd0, b_req_ready}, 32'd1);
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h8;
      b_done = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         check_output("ws0_b2b/rsp_valid", {31'd0, b_rsp_valid}, ((i % 2) == 0) ? 32'd1 : 32'd0);
         if (b_rsp_valid) begin
            b_done++;
            check_output("ws0_b2b/rdata", b_rsp_rdata, 32'hA5A50001);
         end
      end
      b_req_valid = 1'b0;
      check_output("ws0_b2b/completions", 32'(b_done), 32'd5);
      step();
      b_req_valid = 1'b1; b_req_addr = 32'h3;
      step();
      b_req_valid = 1'b0;
      check_output("ws0_misaligned/error", {31'd0, b_rsp_error}, 32'd1);
      check_output("ws0_misaligned/rdata", b_rsp_rdata, 32'd0);
      step();
      check_output("ws0_misaligned/idle", {31'd0, b_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
